// File: rtl/pipe_ctrl_seq.sv
// Pipeline stall/flush controller: merges stall requests, redirects on exceptions
// (deferring while the bus is busy), stretches flush and watches for endless stalls.
module pipe_ctrl_seq #(
    parameter int                      NSTAGE         = 8,
    parameter int                      NREQ           = 5,
    // Slice i (bits [i*NSTAGE +: NSTAGE]) is the stall vector of request i: load=0F, ex=1F, rest=7F
    parameter logic [NREQ*NSTAGE-1:0] STALL_MASK     = 40'h7F7F7F1F0F,
    parameter logic [31:0]             EXC_VECTOR     = 32'hbfc00380,
    parameter logic [31:0]             EXC_CODE_MASK  = 32'h00003732,
    parameter logic [31:0]             ERET_CODE      = 32'h0000000e,
    parameter int                      FLUSH_CYCLES   = 1,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stallreq_i,
    input  logic              mem_busy_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              exc_pending_o,
    output logic              stall_timeout_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DEFER = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       target_q, target_d;
    logic [WD_W-1:0]   wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;

    logic [31:0]       exc_target;
    logic [NSTAGE-1:0] merged_stall;
    logic [NSTAGE-1:0] stall_c;
    logic              flush_c;
    logic [31:0]       new_pc_c;
    logic              pending_c;

    always_comb begin
        exc_target = 32'h0;
        if (excepttype_i == ERET_CODE) begin
            exc_target = cp0_epc_i;
        end else if ((excepttype_i < 32'd32) && EXC_CODE_MASK[excepttype_i[4:0]]) begin
            exc_target = EXC_VECTOR;
        end
    end

    always_comb begin
        merged_stall = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stallreq_i[i]) begin
                merged_stall = merged_stall | STALL_MASK[i*NSTAGE +: NSTAGE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        stall_c   = '0;
        flush_c   = 1'b0;
        new_pc_c  = 32'h0;
        pending_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (excepttype_i != 32'h0) begin
                    target_d = exc_target;
                    if (mem_busy_i) begin
                        stall_c   = '1;
                        pending_c = 1'b1;
                        state_d   = ST_DEFER;
                    end else begin
                        flush_c  = 1'b1;
                        new_pc_c = exc_target;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end
                end else begin
                    stall_c = merged_stall;
                end
            end
            ST_DEFER: begin
                pending_c = 1'b1;
                if (mem_busy_i) begin
                    stall_c = '1;
                end else begin
                    flush_c  = 1'b1;
                    new_pc_c = target_q;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                flush_c  = 1'b1;
                new_pc_c = target_q;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst) begin
            stall_c   = '0;
            flush_c   = 1'b0;
            new_pc_c  = 32'h0;
            pending_c = 1'b0;
        end
    end

    // Watchdog counts cycles with any stall asserted and saturates at the limit
    always_comb begin
        wcnt_d = '0;
        if (stall_c != '0) begin
            wcnt_d = (wcnt_q == WD_MAX) ? wcnt_q : wcnt_q + WD_W'(1);
        end
        timeout_d = timeout_q | ((TIMEOUT_CYCLES != 0) && (wcnt_d == WD_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            target_q  <= 32'h0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_o         = stall_c;
    assign flush_o         = flush_c;
    assign new_pc_o        = new_pc_c;
    assign exc_pending_o   = pending_c;
    assign stall_timeout_o = timeout_q & ~rst;

endmodule
